sqrt_stream: RTL and testbench

SQRT_STREAM -- requirements
Module: sqrt_stream

---
 rtl/sqrt_stream.sv | 156 +++++++++++++++
 tb/tb_sqrt_stream.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_stream.sv
// sqrt_stream -- streaming unsigned fixed-point square root.
//
// Computes the square root of an unsigned Q(WIDTH-FBITS).FBITS radicand with
// a restoring digit-by-digit algorithm that produces one root bit per clock.
// The radicand is scaled left by FBITS so that the integer root of the scaled
// value is already in the same fixed-point format as the input.
// Each operation takes ITER = (WIDTH+FBITS)/2 cycles in CALC.
//
// Build option:
//   SQRT_ROUND_EN  defined   -> out_root is rounded to nearest (saturating);
//                  undefined -> out_root is the truncated root.
//   out_rem is always the unrounded remainder.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   radicand handshake (in_rad, in_tag)
//   abort                 cancels an operation in CALC
//   busy                  high while a calculation is running
//   out_valid / out_ready result handshake (out_root, out_rem, out_tag)
module sqrt_stream #(
    parameter int WIDTH = 16,
    parameter int FBITS = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_rad,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             abort,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_root,
    output logic [WIDTH-1:0] out_rem,
    output logic [TAG_W-1:0] out_tag
);

    localparam int ITER = (WIDTH + FBITS) / 2;   // root bits produced
    localparam int RW   = ITER;                  // working root width
    localparam int SW   = WIDTH + FBITS;         // scaled radicand width
    localparam int AW   = WIDTH + 2;             // remainder accumulator width
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg, state_next;
    logic [SW-1:0]    rad_reg;
    logic [AW-1:0]    rem_reg;
    logic [RW-1:0]    root_reg;
    logic [CW-1:0]    cnt_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [WIDTH-1:0] out_root_reg, out_rem_reg;
    logic [TAG_W-1:0] out_tag_reg;

    logic             accept;
    logic             last_iter;
    logic [AW-1:0]    rem_shift, trial, rem_step;
    logic             ge;
    logic [RW-1:0]    root_step;
    logic [WIDTH-1:0] root_ext, root_final;

    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_reg == CALC);
    assign out_valid = (state_reg == DONE);
    assign last_iter = (cnt_reg == CW'(ITER - 1));

    assign out_root = out_root_reg;
    assign out_rem  = out_rem_reg;
    assign out_tag  = out_tag_reg;

    // One restoring step: bring down the next two radicand bits and try to
    // subtract 4*root+1; success sets the new root bit.
    always_comb begin
        rem_shift = (rem_reg << 2) | AW'(rad_reg[SW-1 -: 2]);
        trial     = {{(AW-RW-2){1'b0}}, root_reg, 2'b01};
        ge        = (rem_shift >= trial);
        rem_step  = ge ? (rem_shift - trial) : rem_shift;
        root_step = {root_reg[RW-2:0], ge};
        root_ext  = {{(WIDTH-RW){1'b0}}, root_step};
    end

`ifdef SQRT_ROUND_EN
    // sqrt(x) >= r + 0.5 exactly when the integer remainder exceeds r.
    always_comb begin
        root_final = root_ext;
        if ((rem_step > {{(AW-RW){1'b0}}, root_step}) && (root_ext != '1))
            root_final = root_ext + WIDTH'(1);
    end
`else
    assign root_final = root_ext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid) state_next = CALC;
            CALC: begin
                if (abort)
                    state_next = IDLE;
                else if (last_iter)
                    state_next = DONE;
            end
            DONE: begin
                // Retiring and accepting can happen on the same edge.
                if (out_ready)
                    state_next = in_valid ? CALC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_reg      <= '0;
            rem_reg      <= '0;
            root_reg     <= '0;
            cnt_reg      <= '0;
            tag_reg      <= '0;
            out_root_reg <= '0;
            out_rem_reg  <= '0;
            out_tag_reg  <= '0;
        end else begin
            if (accept) begin
                rad_reg  <= {in_rad, {FBITS{1'b0}}};
                rem_reg  <= '0;
                root_reg <= '0;
                cnt_reg  <= '0;
                tag_reg  <= in_tag;
            end else if (state_reg == CALC) begin
                rad_reg  <= rad_reg << 2;
                rem_reg  <= rem_step;
                root_reg <= root_step;
                cnt_reg  <= cnt_reg + CW'(1);
            end

            // Results are published only on a completed, non-aborted run,
            // so they stay put for the whole DONE phase.
            if ((state_reg == CALC) && !abort && last_iter) begin
                out_root_reg <= root_final;
                out_rem_reg  <= rem_step[WIDTH-1:0];
                out_tag_reg  <= tag_reg;
            end
        end
    end

endmodule

// File: tb/tb_sqrt_stream.sv
module tb_sqrt_stream;

    localparam int ITER = 12;

`ifdef SQRT_ROUND_EN
    localparam logic [15:0] ROOT_3    = 16'h001C;
    localparam logic [15:0] ROOT_FFFF = 16'h1000;
`else
    localparam logic [15:0] ROOT_3    = 16'h001B;
    localparam logic [15:0] ROOT_FFFF = 16'h0FFF;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_rad;
    logic [3:0]  in_tag;
    logic        abort;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_root;
    logic [15:0] out_rem;
    logic [3:0]  out_tag;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sqrt_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rad    (in_rad),
        .in_tag    (in_tag),
        .abort     (abort),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_root  (out_root),
        .out_rem   (out_rem),
        .out_tag   (out_tag)
    );

    typedef struct {
        logic [15:0] rad;
        logic [3:0]  tag;
        logic [15:0] root;
        logic [15:0] rem;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference: largest r with r*r <= rad*2^8, found by bisection.
    function automatic void model(input logic [15:0] rad,
                                  output logic [15:0] root, output logic [15:0] rem);
        longint s, lo, hi, mid, r;
        s  = longint'(rad) * 256;
        lo = 0;
        hi = 4096;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= s) lo = mid;
            else hi = mid;
        end
        r   = lo;
        rem = 16'(s - r * r);
`ifdef SQRT_ROUND_EN
        if ((s - r * r) > r && r < 65535) r = r + 1;
`endif
        root = 16'(r);
    endfunction

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic launch(input logic [15:0] rad, input logic [3:0] tag);
        int guard = 0;
        in_rad   = rad;
        in_tag   = tag;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edges counted after the accepting edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, ".retired"}, 32'(out_valid), 32'd0);
        check({name, ".idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_op(input string name, input logic [15:0] rad, input logic [3:0] tag,
                         input logic [15:0] exp_root, input logic [15:0] exp_rem);
        int lat;
        launch(rad, tag);
        check({name, ".busy"}, 32'(busy), 32'd1);
        wait_valid(lat);
        check({name, ".latency"}, lat, ITER);
        check({name, ".root"}, 32'(out_root), 32'(exp_root));
        check({name, ".rem"}, 32'(out_rem), 32'(exp_rem));
        check({name, ".tag"}, 32'(out_tag), 32'(tag));
        $display("op %s rad=%h tag=%0d root=%h rem=%h lat=%0d", name, rad, tag, out_root, out_rem, lat);
        retire(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   lat;
        int   seen;
        logic [15:0] r_rad, r_root, r_rem;
        logic [3:0]  r_tag;

        tbl[0] = '{16'hE890, 4'd3, 16'h0F40, 16'h0000};
        tbl[1] = '{16'h0200, 4'd1, 16'h016A, 16'h001C};
        tbl[2] = '{16'h0040, 4'd2, 16'h0080, 16'h0000};
        tbl[3] = '{16'h0003, 4'd4, ROOT_3,   16'h0027};
        tbl[4] = '{16'hFFFF, 4'd5, ROOT_FFFF, 16'h1EFF};
        tbl[5] = '{16'h0000, 4'd6, 16'h0000, 16'h0000};
        tbl[6] = '{16'h0100, 4'd7, 16'h0100, 16'h0000};

        rst_n = 1'b0; in_valid = 1'b0; in_rad = '0; in_tag = '0;
        abort = 1'b0; out_ready = 1'b0;
        #3;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.out_root", 32'(out_root), 32'd0);
        check("reset.out_rem", 32'(out_rem), 32'd0);
        check("reset.out_tag", 32'(out_tag), 32'd0);
        #19;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            do_op($sformatf("vec%0d", i), tbl[i].rad, tbl[i].tag, tbl[i].root, tbl[i].rem);

        // Output stall with a new radicand waiting, then back-to-back hand-over.
        launch(16'h0200, 4'd1);
        wait_valid(lat);
        check("stall.first_latency", lat, ITER);
        in_rad = 16'h0040; in_tag = 4'd6; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d.out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d.root", i), 32'(out_root), 32'h016A);
            check($sformatf("stall%0d.rem", i), 32'(out_rem), 32'h001C);
            check($sformatf("stall%0d.tag", i), 32'(out_tag), 32'd1);
            check($sformatf("stall%0d.in_ready", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("b2b.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        check("b2b.out_valid_cleared", 32'(out_valid), 32'd0);
        check("b2b.busy", 32'(busy), 32'd1);
        wait_valid(lat);
        check("b2b.latency", lat, ITER);
        check("b2b.root", 32'(out_root), 32'h0080);
        check("b2b.tag", 32'(out_tag), 32'd6);
        $display("op b2b root=%h tag=%0d lat=%0d", out_root, out_tag, lat);
        retire("b2b");

        // Abort in the 4th CALC cycle.
        launch(16'hE890, 4'd9);
        repeat (3) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check("abort.no_result", seen, 0);
        $display("op abort seen_valid=%0d", seen);

        // Abort while a result is pending is ignored.
        launch(16'h0003, 4'd2);
        wait_valid(lat);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_done.out_valid", 32'(out_valid), 32'd1);
        check("abort_done.root", 32'(out_root), 32'(ROOT_3));
        check("abort_done.tag", 32'(out_tag), 32'd2);
        $display("op abort_done root=%h tag=%0d", out_root, out_tag);
        retire("abort_done");

        // Asynchronous reset in the middle of CALC.
        launch(16'hFFFF, 4'hA);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("rst_mid.busy", 32'(busy), 32'd0);
        check("rst_mid.in_ready", 32'(in_ready), 32'd1);
        check("rst_mid.out_valid", 32'(out_valid), 32'd0);
        check("rst_mid.out_root", 32'(out_root), 32'd0);
        check("rst_mid.out_rem", 32'(out_rem), 32'd0);
        check("rst_mid.out_tag", 32'(out_tag), 32'd0);
        $display("op rst_mid busy=%0d out_valid=%0d root=%h", busy, out_valid, out_root);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_rst", 16'h0100, 4'd7, 16'h0100, 16'h0000);

        // Random radicands against the reference model.
        for (int i = 0; i < 24; i++) begin
            r_rad = 16'($urandom);
            r_tag = 4'($urandom);
            model(r_rad, r_root, r_rem);
            do_op($sformatf("rnd%0d", i), r_rad, r_tag, r_root, r_rem);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
